i2c_req_arbiter: RTL and testbench
==================================

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Purpose: shares one I2C core between NUM_REQ requesters. It accepts a transaction, launches the core, waits for completion or timeout, and returns the result.

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning number of requesters (legal range 2..4).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1_000_000, meaning the clk-cycle limit per transaction (legal range 2..2^24-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester transaction request.
REQ-006 The block SHALL have port req_ready, output, NUM_REQ bits: one-cycle accept pulse to the granted requester.
REQ-007 The block SHALL have port req_data0, input, 32*NUM_REQ bits: per-requester command word; requester i uses slice [32i+31:32i].
REQ-008 The block SHALL have port req_data1, input, 32*NUM_REQ bits: per-requester write-data word; same slicing as req_data0.
REQ-009 The block SHALL have port rsp_valid, output, NUM_REQ bits: response valid, asserted only to the owner.
REQ-010 The block SHALL have port rsp_ready, input, NUM_REQ bits: per-requester response accept.
REQ-011 The block SHALL have port rsp_data, output, 32 bits: read data captured from core_data2.
REQ-012 The block SHALL have port rsp_err, output, 1 bit: timeout flag for the current response.
REQ-013 The block SHALL have ports core_data0 and core_data1, outputs, 32 bits each: command and write data to the I2C core.
REQ-014 The block SHALL have port core_start, output, 1 bit: one-cycle launch pulse to the core.
REQ-015 The block SHALL have ports core_busy and core_done, inputs, 1 bit each: core status.
REQ-016 The block SHALL have port core_data2, input, 32 bits: core read buffer.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, with exactly one state active.
REQ-018 In IDLE, if any req_valid is high, the block SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ.
- On grant it SHALL pulse req_ready[g] for one cycle.
- It SHALL register req_data0/1 slice g into core_data0/1.
- It SHALL go to ISSUE.
REQ-019 core_data0/1 SHALL hold their captured values from the grant until the FSM re-enters IDLE.
REQ-020 In ISSUE the block SHALL drive core_start=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-021 In WAIT_BUSY:
- core_done=1 SHALL go to RESP, taking priority over core_busy.
- Otherwise core_busy=1 SHALL go to WAIT_DONE.
REQ-022 In WAIT_DONE, core_done=1 SHALL capture core_data2 into rsp_data, clear rsp_err, and go to RESP.
REQ-023 A 24-bit cycle counter SHALL be cleared in ISSUE and SHALL increment in WAIT_BUSY and WAIT_DONE.
- When it reaches TIMEOUT_CYC-1 without core_done, the block SHALL set rsp_err=1 and rsp_data=0 and go to RESP.
- If core_done and the timeout occur in the same cycle, core_done SHALL win.
REQ-024 In RESP the block SHALL hold rsp_valid[g]=1 and rsp_data/rsp_err stable until rsp_ready[g]=1.
- On that accept it SHALL set last_grant=g and return to IDLE, so rsp_valid falls on the next cycle.
REQ-025 No new grant SHALL be issued while the FSM is not in IDLE.
REQ-026 Minimum back-to-back spacing SHALL be one IDLE cycle between transactions.
REQ-027 A requester dropping req_valid before its grant SHALL be legal and SHALL cause no grant; requests are not stored.
REQ-028 core_done or core_busy seen in IDLE, ISSUE or RESP SHALL be ignored.
REQ-029 rsp_ready from a non-owner SHALL be ignored.

Reset
REQ-030 On reset, the block SHALL set:
- state=IDLE and last_grant=NUM_REQ-1, so requester 0 wins first;
- req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0;
- core_data0=0, core_data1=0, core_start=0;
- the timeout counter to 0.
REQ-031 Reset asserted mid-transaction SHALL abort at once with no response; the core is reset independently by its own reset.

Structure
REQ-032 The state encoding, a clog2 helper and the timeout counter width SHALL live in the shared package i2c_pkg.
REQ-033 The round-robin grant selection SHALL be the sub-module i2c_rr_sel.
- Inputs: request vector and last_grant.
- Output: grant index plus a valid flag.
- It SHALL be purely combinational.
REQ-034 This block SHALL sit between the CSR/requesters and the I2C core.

Verification
REQ-035 Single request: req0 with data0=0x0000_A051 -> req_ready[0] pulses, core_start pulses next cycle; core busy 10 cycles then done with data2=0x5A -> rsp_valid[0], rsp_data=0x0000_005A, rsp_err=0.
REQ-036 Simultaneous requests: req0 and req1 both asserted repeatedly for 4 transactions -> grant order 0,1,0,1 after reset.
REQ-037 Timeout: TIMEOUT_CYC=50, core never signals done -> rsp_valid rises 50 cycles after core_start, rsp_err=1, rsp_data=0.
REQ-038 Done without busy: core_done the cycle after core_start, busy never high -> RESP reached and data2 captured.
REQ-039 Response backpressure: rsp_ready held low for 20 cycles while req1 valid -> no req_ready[1] until rsp_ready[0] is accepted; rsp_data stays stable.
REQ-040 Mid-transaction reset: reset in WAIT_DONE -> next cycle all outputs reach their REQ-030 values, and the next grant goes to req0.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding, timeout counter width and clog2 helper
package i2c_pkg;
  localparam int CNT_W = 24;
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/i2c_rr_sel.sv
// i2c_rr_sel: combinational round-robin pick starting after last
module i2c_rr_sel import i2c_pkg::*; #(
  parameter int NUM_REQ = 2,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      gnt,
  output logic               gnt_valid
);
  always_comb begin
    gnt = '0;
    gnt_valid = 1'b0;
    // later iterations override earlier ones, so last+1 has top priority
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        gnt = IW'((int'(last) + k) % NUM_REQ);
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one I2C core between NUM_REQ requesters
module i2c_req_arbiter import i2c_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_data0,
  input  logic [32*NUM_REQ-1:0]  req_data1,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic [31:0]            core_data0,
  output logic [31:0]            core_data1,
  output logic                   core_start,
  input  logic                   core_busy,
  input  logic                   core_done,
  input  logic [31:0]            core_data2
);
  localparam int IW = clog2(NUM_REQ);
  state_t            state;
  logic [IW-1:0]     last_grant, owner, sel;
  logic              sel_valid, to_hit;
  logic [CNT_W-1:0]  cnt;
  i2c_rr_sel #(.NUM_REQ(NUM_REQ)) u_sel (
    .req       (req_valid),
    .last      (last_grant),
    .gnt       (sel),
    .gnt_valid (sel_valid)
  );
  assign to_hit = cnt == CNT_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      owner      <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      core_data0 <= '0;
      core_data1 <= '0;
      core_start <= 1'b0;
      cnt        <= '0;
    end else begin
      req_ready  <= '0;
      core_start <= 1'b0;
      case (state)
        IDLE: if (sel_valid) begin
          owner      <= sel;
          req_ready  <= NUM_REQ'(1) << sel;
          core_data0 <= req_data0[32*int'(sel) +: 32];
          core_data1 <= req_data1[32*int'(sel) +: 32];
          state      <= ISSUE;
        end
        ISSUE: begin
          core_start <= 1'b1;
          cnt        <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          // done beats both busy and a coincident timeout
          if (core_done) begin
            rsp_data  <= core_data2;
            rsp_err   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= RESP;
          end else if (to_hit) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= RESP;
          end else if (state == WAIT_BUSY && core_busy) begin
            state <= WAIT_DONE;
          end
        end
        RESP: if (rsp_ready[owner]) begin
          rsp_valid  <= '0;
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: table-driven transactions plus timeout, backpressure and reset sequences
module tb_i2c_req_arbiter;
  localparam int N = 2;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0, rsp_ready = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [32*N-1:0] req_data0 = '0, req_data1 = '0;
  logic [31:0] rsp_data, core_data0, core_data1;
  logic [31:0] core_data2 = '0;
  logic rsp_err, core_start;
  logic core_busy = 1'b0, core_done = 1'b0;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [N-1:0] mask;
    logic [31:0]  d0;
    logic [31:0]  d1;
    int           busy;
    logic [31:0]  d2;
    int           g;
  } vec_t;
  vec_t vecs[7];
  i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .core_data0 (core_data0),
    .core_data1 (core_data1),
    .core_start (core_start),
    .core_busy  (core_busy),
    .core_done  (core_done),
    .core_data2 (core_data2)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  task automatic drive_req(input logic [N-1:0] mask, input logic [31:0] d0, input logic [31:0] d1);
    for (int i = 0; i < N; i++) begin
      req_data0[32*i +: 32] = d0 + 32'(i);
      req_data1[32*i +: 32] = d1 + 32'(i);
    end
    req_valid = mask;
  endtask
  task automatic await_grant(input int g);
    int n;
    n = 0;
    while (req_ready == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("grant", 32'(req_ready), 32'(1) << g);
    req_valid = '0;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_core_data0"}, core_data0, 0);
    chk({tag, "_core_data1"}, core_data1, 0);
    chk({tag, "_core_start"}, 32'(core_start), 0);
  endtask
  task automatic run_txn(input vec_t v);
    drive_req(v.mask, v.d0, v.d1);
    await_grant(v.g);
    chk("core_data0", core_data0, v.d0 + 32'(v.g));
    chk("core_data1", core_data1, v.d1 + 32'(v.g));
    chk("start_before", 32'(core_start), 0);
    tick();
    chk("core_start", 32'(core_start), 1);
    tick();
    chk("start_pulse", 32'(core_start), 0);
    core_busy = v.busy > 0;
    repeat (v.busy) tick();
    core_busy = 1'b0;
    core_done = 1'b1;
    core_data2 = v.d2;
    chk("rsp_early", 32'(rsp_valid), 0);
    tick();
    core_done = 1'b0;
    core_data2 = 32'hFFFF_FFFF;
    chk("rsp_valid", 32'(rsp_valid), 32'(1) << v.g);
    chk("rsp_data", rsp_data, v.d2);
    chk("rsp_err", 32'(rsp_err), 0);
    rsp_ready = N'(1) << v.g;
    tick();
    rsp_ready = '0;
    chk("rsp_drop", 32'(rsp_valid), 0);
  endtask
  initial begin
    int n, bad;
    vecs[0] = '{2'b11, 32'h0000_1000, 32'hD000_0000, 3, 32'h0000_0011, 0};
    vecs[1] = '{2'b11, 32'h0000_2000, 32'hD100_0000, 5, 32'h0000_0022, 1};
    vecs[2] = '{2'b11, 32'h0000_3000, 32'hD200_0000, 1, 32'h0000_0033, 0};
    vecs[3] = '{2'b11, 32'h0000_4000, 32'hD300_0000, 2, 32'h0000_0044, 1};
    vecs[4] = '{2'b01, 32'h0000_A051, 32'h0000_0000, 10, 32'h0000_005A, 0};
    vecs[5] = '{2'b10, 32'h0000_5555, 32'h1234_0000, 0, 32'hCAFE_F00D, 1};
    vecs[6] = '{2'b11, 32'h0000_6000, 32'hD600_0000, 0, 32'h0000_0077, 0};
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    foreach (vecs[i]) run_txn(vecs[i]);
    // timeout: core never finishes
    drive_req(2'b01, 32'h0000_00A0, 32'h0000_00B0);
    await_grant(0);
    tick();
    chk("to_start", 32'(core_start), 1);
    core_busy = 1'b1;
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), TO);
    chk("to_valid", 32'(rsp_valid), 1);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_data", rsp_data, 0);
    core_busy = 1'b0;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    chk("to_drop", 32'(rsp_valid), 0);
    // response backpressure with a competing request and non-owner ready
    drive_req(2'b01, 32'h0000_00C0, 32'h0000_00C1);
    await_grant(0);
    tick();
    tick();
    core_done = 1'b1;
    core_data2 = 32'h0000_BEEF;
    tick();
    core_done = 1'b0;
    core_data2 = '0;
    chk("bp_valid", 32'(rsp_valid), 1);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    core_done = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (req_ready != '0 || rsp_valid != 2'b01 || rsp_data != 32'h0000_BEEF || rsp_err) bad++;
    end
    chk("bp_stable", 32'(bad), 0);
    core_done = 1'b0;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    chk("bp_release", 32'(rsp_valid), 0);
    chk("bp_no_grant_yet", 32'(req_ready), 0);
    tick();
    chk("bp_grant1", 32'(req_ready), 2);
    req_valid = '0;
    tick();
    tick();
    core_done = 1'b1;
    core_data2 = 32'h0000_1234;
    tick();
    core_done = 1'b0;
    chk("bp_rsp1", 32'(rsp_valid), 2);
    chk("bp_data1", rsp_data, 32'h0000_1234);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;
    run_txn('{2'b01, 32'h0000_0D00, 32'h0000_0D10, 0, 32'h0000_0D20, 0});
    // mid-transaction reset in WAIT_DONE
    drive_req(2'b01, 32'h0000_00E0, 32'h0000_00E1);
    await_grant(0);
    tick();
    tick();
    core_busy = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    core_busy = 1'b0;
    bad = 0;
    repeat (3) begin
      tick();
      if (rsp_valid != '0 || req_ready != '0 || core_start) bad++;
    end
    chk("mr_quiet", 32'(bad), 0);
    drive_req(2'b11, 32'h0000_00F0, 32'h0000_00F1);
    await_grant(0);
    chk("mr_core_data0", core_data0, 32'h0000_00F0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
